// File: rtl/sync_fifo_v2_pkg.sv
// sync_fifo_v2 shared package
// address width helper and parameter legality checks
package fifo_pkg;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(
    input int width,
    input int depth,
    input int af,
    input int ae
  );
    return (width >= 1) && (depth >= 2) &&
           is_pow2(depth) &&
           (af >= 0) && (af <= depth) &&
           (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/sync_fifo_v2_if.sv
// sync_fifo_v2 handshake/status interface
// master drives requests, slave is the fifo
interface sync_fifo_v2_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  import fifo_pkg::*;

  localparam int AW = addr_w(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             clear_err;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [AW:0]      level;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, wr_data,
    output rd_en, clear_err,
    input  rd_data, rd_valid, level,
    input  full, empty,
    input  almost_full, almost_empty,
    input  overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data,
    input  rd_en, clear_err,
    output rd_data, rd_valid, level,
    output full, empty,
    output almost_full, almost_empty,
    output overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_v2_mem.sv
// fifo_mem: WIDTH x DEPTH register array
// registered read port (standard) or combinational (FWFT)
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = 0,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else if (re) begin
      rd_q <= mem[raddr];
    end
  end

  assign rdata = (FWFT != 0) ? mem[raddr] : rd_q;

endmodule

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock fifo with FWFT option,
// programmable thresholds, sticky errors and flush
module sync_fifo_v2
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_v2_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] FULLV = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_L  = (AW+1)'(AE_THRESH);

  if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH))
  begin : g_bad_param
    $error("sync_fifo_v2: illegal parameters");
  end

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] level;
  logic        full;
  logic        empty;
  logic        wr_acc;
  logic        rd_acc;
  logic        pop_q;
  logic        ovf_q;
  logic        unf_q;

  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == FULLV);
  assign empty  = (wr_ptr == rd_ptr);
  assign wr_acc = bus.wr_en & ~full & ~bus.flush;
  assign rd_acc = bus.rd_en & ~empty & ~bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pop_q  <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pop_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      pop_q <= rd_acc;
    end
  end

  // a new error in the same cycle beats clear_err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full) ovf_q <= 1'b1;
      else if (bus.clear_err) ovf_q <= 1'b0;
      if (bus.rd_en && empty) unf_q <= 1'b1;
      else if (bus.clear_err) unf_q <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FWFT  (FWFT),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid     = (FWFT != 0) ? ~empty : pop_q;
  assign bus.level        = level;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level >= AF_L);
  assign bus.almost_empty = (level <= AE_L);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: directed tests on a standard
// and a FWFT instance sharing clk/rst
module tb_sync_fifo_v2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  sync_fifo_v2_if #(.WIDTH(8), .DEPTH(16)) s ();
  sync_fifo_v2_if #(.WIDTH(8), .DEPTH(16)) f ();

  sync_fifo_v2 #(
    .WIDTH(8), .DEPTH(16), .FWFT(0),
    .AF_THRESH(14), .AE_THRESH(2)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (s)
  );

  sync_fifo_v2 #(
    .WIDTH(8), .DEPTH(16), .FWFT(1),
    .AF_THRESH(14), .AE_THRESH(2)
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    s.flush = 0; s.wr_en = 0; s.wr_data = '0;
    s.rd_en = 0; s.clear_err = 0;
    f.flush = 0; f.wr_en = 0; f.wr_data = '0;
    f.rd_en = 0; f.clear_err = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    step();
    step();
    n_chk++;
    if ({s.empty, s.full, s.almost_empty,
         s.almost_full, s.overflow,
         s.underflow, s.rd_valid} !== 7'b1010000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 1010000",
        {s.empty, s.full, s.almost_empty,
         s.almost_full, s.overflow,
         s.underflow, s.rd_valid});
    end
    n_chk++;
    if (s.level !== 5'd0 || s.rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_level_data: got %0d/%h want 0/00",
        s.level, s.rd_data);
    end
    n_chk++;
    if ({f.empty, f.rd_valid, f.underflow} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_fwft: got %b want 100",
        {f.empty, f.rd_valid, f.underflow});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      s.wr_en = 1; s.wr_data = 8'(i);
      step();
    end
    n_chk++;
    if ({s.full, s.level} !== {1'b1, 5'd16}) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b lvl=%0d want 1/16",
        s.full, s.level);
    end
    s.wr_data = 8'hFF;
    step();
    s.wr_en = 0;
    n_chk++;
    if ({s.overflow, s.level} !== {1'b1, 5'd16}) begin
      n_fail++;
      $display("FAIL fill_ovf: got ovf=%b lvl=%0d want 1/16",
        s.overflow, s.level);
    end
    for (int i = 0; i < 16; i++) begin
      s.rd_en = 1;
      step();
      n_chk++;
      if ({s.rd_valid, s.rd_data} !== {1'b1, 8'(i)}) begin
        n_fail++;
        $display("FAIL drain_%0d: got v=%b d=%h want 1/%h",
          i, s.rd_valid, s.rd_data, 8'(i));
      end
    end
    s.rd_en = 0;
    step();
    n_chk++;
    if ({s.empty, s.rd_valid, s.rd_data} !== {2'b10, 8'h0F}) begin
      n_fail++;
      $display("FAIL drain_end: got e=%b v=%b d=%h want 1/0/0f",
        s.empty, s.rd_valid, s.rd_data);
    end
    s.clear_err = 1;
    step();
    s.clear_err = 0;
    n_chk++;
    if (s.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b want 0", s.overflow);
    end
  endtask

  task automatic test_fwft();
    f.wr_en = 1; f.wr_data = 8'hA5;
    step();
    f.wr_en = 0;
    n_chk++;
    if ({f.empty, f.rd_valid, f.rd_data} !== {2'b01, 8'hA5}) begin
      n_fail++;
      $display("FAIL fwft_head: got e=%b v=%b d=%h want 0/1/a5",
        f.empty, f.rd_valid, f.rd_data);
    end
    f.rd_en = 1;
    step();
    f.rd_en = 0;
    n_chk++;
    if ({f.empty, f.rd_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL fwft_pop: got e=%b v=%b want 1/0",
        f.empty, f.rd_valid);
    end
    f.rd_en = 1;
    step();
    f.rd_en = 0;
    n_chk++;
    if (f.underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL fwft_unf: got %b want 1", f.underflow);
    end
    f.clear_err = 1;
    step();
    f.clear_err = 0;
    n_chk++;
    if (f.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fwft_unf_clr: got %b want 0", f.underflow);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      s.wr_en = 1; s.wr_data = 8'(8'h10 + i);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      s.wr_en = 1; s.rd_en = 1;
      s.wr_data = 8'(8'h13 + i);
      step();
      n_chk++;
      if ({s.rd_valid, s.rd_data, s.level} !==
          {1'b1, 8'(8'h10 + i), 5'd3}) begin
        n_fail++;
        $display("FAIL wrap_%0d: got v=%b d=%h l=%0d want 1/%h/3",
          i, s.rd_valid, s.rd_data, s.level, 8'(8'h10 + i));
      end
    end
    s.wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (s.rd_data !== 8'(8'h38 + i)) begin
        n_fail++;
        $display("FAIL wrap_tail_%0d: got %h want %h",
          i, s.rd_data, 8'(8'h38 + i));
      end
    end
    s.rd_en = 0;
    step();
    n_chk++;
    if ({s.empty, s.overflow, s.underflow} !== 3'b100) begin
      n_fail++;
      $display("FAIL wrap_flags: got %b want 100",
        {s.empty, s.overflow, s.underflow});
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      s.wr_en = 1; s.wr_data = 8'(8'h40 + i);
      step();
    end
    s.rd_en = 1; s.wr_data = 8'hEE;
    step();
    s.wr_en = 0; s.rd_en = 0;
    n_chk++;
    if ({s.level, s.overflow, s.rd_valid, s.rd_data} !==
        {5'd15, 2'b11, 8'h40}) begin
      n_fail++;
      $display("FAIL sim_full: got l=%0d o=%b v=%b d=%h want 15/1/1/40",
        s.level, s.overflow, s.rd_valid, s.rd_data);
    end
    s.rd_en = 1;
    for (int i = 0; i < 15; i++) step();
    s.rd_en = 0;
    n_chk++;
    if ({s.empty, s.rd_data} !== {1'b1, 8'h4F}) begin
      n_fail++;
      $display("FAIL sim_full_tail: got e=%b d=%h want 1/4f",
        s.empty, s.rd_data);
    end
    s.clear_err = 1;
    step();
    s.clear_err = 0;
    s.wr_en = 1; s.rd_en = 1; s.wr_data = 8'h77;
    step();
    s.wr_en = 0; s.rd_en = 0;
    n_chk++;
    if ({s.level, s.underflow, s.rd_valid} !== {5'd1, 2'b10}) begin
      n_fail++;
      $display("FAIL sim_empty: got l=%0d u=%b v=%b want 1/1/0",
        s.level, s.underflow, s.rd_valid);
    end
    s.rd_en = 1;
    step();
    s.rd_en = 0;
    n_chk++;
    if ({s.rd_valid, s.rd_data} !== {1'b1, 8'h77}) begin
      n_fail++;
      $display("FAIL sim_empty_rd: got v=%b d=%h want 1/77",
        s.rd_valid, s.rd_data);
    end
    s.clear_err = 1;
    step();
    s.clear_err = 0;
    n_chk++;
    if ({s.overflow, s.underflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL sim_err_clr: got %b want 00",
        {s.overflow, s.underflow});
    end
  endtask

  task automatic test_thresholds();
    for (int n = 1; n <= 16; n++) begin
      s.wr_en = 1; s.wr_data = 8'(8'h80 + n);
      step();
      n_chk++;
      if ({s.almost_empty, s.almost_full} !==
          {n <= 2, n >= 14}) begin
        n_fail++;
        $display("FAIL thr_up_%0d: got ae=%b af=%b want %b/%b",
          n, s.almost_empty, s.almost_full, n <= 2, n >= 14);
      end
    end
    s.wr_en = 0;
    for (int n = 15; n >= 0; n--) begin
      s.rd_en = 1;
      step();
      n_chk++;
      if ({s.almost_empty, s.almost_full} !==
          {n <= 2, n >= 14}) begin
        n_fail++;
        $display("FAIL thr_dn_%0d: got ae=%b af=%b want %b/%b",
          n, s.almost_empty, s.almost_full, n <= 2, n >= 14);
      end
    end
    s.rd_en = 0;
    step();
  endtask

  task automatic test_reset_flush();
    s.rd_en = 1;
    step();
    s.rd_en = 0;
    for (int i = 0; i < 9; i++) begin
      s.wr_en = 1; s.wr_data = 8'(8'h60 + i);
      step();
    end
    n_chk++;
    if ({s.level, s.underflow} !== {5'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_rst: got l=%0d u=%b want 9/1",
        s.level, s.underflow);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({s.level, s.rd_data} !== {5'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL async_rst_lvl: got l=%0d d=%h want 0/00",
        s.level, s.rd_data);
    end
    n_chk++;
    if ({s.empty, s.full, s.almost_empty,
         s.almost_full, s.overflow,
         s.underflow, s.rd_valid} !== 7'b1010000) begin
      n_fail++;
      $display("FAIL async_rst_flags: got %b want 1010000",
        {s.empty, s.full, s.almost_empty,
         s.almost_full, s.overflow,
         s.underflow, s.rd_valid});
    end
    s.wr_en = 0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      s.wr_en = 1; s.wr_data = 8'(8'h20 + i);
      step();
    end
    s.wr_en = 0;
    s.rd_en = 1;
    for (int i = 0; i < 11; i++) step();
    n_chk++;
    if ({s.level, s.overflow, s.rd_data} !==
        {5'd5, 1'b1, 8'h2A}) begin
      n_fail++;
      $display("FAIL pre_flush: got l=%0d o=%b d=%h want 5/1/2a",
        s.level, s.overflow, s.rd_data);
    end
    s.flush = 1; s.wr_en = 1; s.wr_data = 8'hCC;
    step();
    idle();
    n_chk++;
    if ({s.level, s.empty, s.overflow, s.rd_valid} !==
        {5'd0, 3'b110}) begin
      n_fail++;
      $display("FAIL flush: got l=%0d e=%b o=%b v=%b want 0/1/1/0",
        s.level, s.empty, s.overflow, s.rd_valid);
    end
    s.wr_en = 1; s.wr_data = 8'h99;
    step();
    s.wr_en = 0; s.rd_en = 1;
    step();
    s.rd_en = 0;
    n_chk++;
    if ({s.rd_valid, s.rd_data, s.empty} !== {1'b1, 8'h99, 1'b1}) begin
      n_fail++;
      $display("FAIL post_flush: got v=%b d=%h e=%b want 1/99/1",
        s.rd_valid, s.rd_data, s.empty);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    idle();
    test_reset();
    test_fill_drain();
    test_fwft();
    test_wrap();
    test_simultaneous();
    test_thresholds();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
